// File: rtl/pipe_pkg.sv
// Shared types for the pipeline controller: FSM state encoding and the
// operand forwarding select encoding.
package pipe_pkg;

    localparam int REG_W = 3;

    typedef enum logic [2:0] {
        RUN,
        MEM_WAIT,
        DRAIN,
        HALTED,
        ERROR
    } stateT;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwdSelT;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/status bundle between the pipeline datapath and pipe_ctrl.
// Optional PIPE_CTRL_PERF_EN adds the stall/flush performance counters.
interface pipe_ctrl_if;
    import pipe_pkg::*;

    logic [REG_W-1:0] id_rs1, id_rs2, idex_rd, exmem_rd, memwb_rd;
    logic             id_uses_rs2, idex_mem_read, exmem_reg_write, memwb_reg_write;
    logic             branch_taken, mem_busy, halt_req, resume;
    logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    fwdSelT           fwd_a, fwd_b;
    logic             halted, err;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0]      stall_cnt, flush_cnt;
`endif

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, idex_rd, idex_mem_read,
               exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write,
               branch_taken, mem_busy, halt_req, resume,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en,
               fwd_a, fwd_b, halted, err
`ifdef PIPE_CTRL_PERF_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, idex_rd, idex_mem_read,
               exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write,
               branch_taken, mem_busy, halt_req, resume,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en,
               fwd_a, fwd_b, halted, err
`ifdef PIPE_CTRL_PERF_EN
        , output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/pipe_ctrl_fwd_unit.sv
// Operand forwarding select for one ID-stage source register.
// The youngest producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] exmemRd,
    input  logic             exmemWr,
    input  logic [REG_W-1:0] memwbRd,
    input  logic             memwbWr,
    output fwdSelT           sel
);

    always_comb begin
        sel = FWD_RF;
        if (memwbWr && (memwbRd != '0) && (memwbRd == rs))
            sel = FWD_MEMWB;
        if (exmemWr && (exmemRd != '0) && (exmemRd == rs))
            sel = FWD_EXMEM;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/sequencing controller: stalls, flushes, halt drain, memory timeout.
// Optional PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
//
// state    | meaning
// RUN      | normal issue, hazards resolved combinationally
// MEM_WAIT | memory busy, pipeline frozen, timeout counting
// DRAIN    | halt requested, fetch stopped while older work retires
// HALTED   | pipeline idle, waits for resume
// ERROR    | memory timeout, only reset leaves
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int WAIT_MAX  = 15,
    parameter int DRAIN_CYC = 3
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    localparam int WCW = $clog2(WAIT_MAX + 1);
    localparam int DCW = $clog2(DRAIN_CYC + 1);
    localparam logic [WCW-1:0] WAIT_TOP   = WCW'(WAIT_MAX);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);

    stateT          stateQ, stateD;
    logic [WCW-1:0] waitQ, waitD, waitInc;
    logic [DCW-1:0] drainQ, drainD;
    logic           loadUse;
    logic           pcEn, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn, memWbEn;

    assign loadUse = bus.idex_mem_read && (bus.idex_rd != '0) &&
                     ((bus.idex_rd == bus.id_rs1) ||
                      (bus.id_uses_rs2 && (bus.idex_rd == bus.id_rs2)));
    assign waitInc = waitQ + WCW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= RUN;
            waitQ  <= '0;
            drainQ <= '0;
        end else begin
            stateQ <= stateD;
            waitQ  <= waitD;
            drainQ <= drainD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        waitD     = '0;
        drainD    = drainQ;
        pcEn      = 1'b1;
        ifIdEn    = 1'b1;
        ifIdFlush = 1'b0;
        idExEn    = 1'b1;
        idExFlush = 1'b0;
        exMemEn   = 1'b1;
        memWbEn   = 1'b1;
        case (stateQ)
            RUN, MEM_WAIT: begin
                if (bus.mem_busy) begin
                    {pcEn, ifIdEn, idExEn, exMemEn, memWbEn} = '0;
                    waitD  = waitInc;
                    stateD = (waitInc == WAIT_TOP) ? ERROR : MEM_WAIT;
                end else if (bus.branch_taken) begin
                    ifIdFlush = 1'b1;
                    idExFlush = 1'b1;
                    stateD    = RUN;
                end else if (loadUse) begin
                    pcEn      = 1'b0;
                    ifIdEn    = 1'b0;
                    idExFlush = 1'b1;
                    stateD    = RUN;
                end else if (bus.halt_req) begin
                    drainD = '0;
                    stateD = DRAIN;
                end else begin
                    stateD = RUN;
                end
            end
            DRAIN: begin
                // a busy memory freezes the drain; the timeout still applies
                if (bus.mem_busy) begin
                    {pcEn, ifIdEn, idExEn, exMemEn, memWbEn} = '0;
                    waitD = waitInc;
                    if (waitInc == WAIT_TOP)
                        stateD = ERROR;
                end else begin
                    pcEn      = 1'b0;
                    ifIdFlush = 1'b1;
                    if (drainQ == DRAIN_LAST) begin
                        drainD = '0;
                        stateD = HALTED;
                    end else begin
                        drainD = drainQ + DCW'(1);
                    end
                end
            end
            HALTED: begin
                {pcEn, ifIdEn, idExEn, exMemEn, memWbEn} = '0;
                if (bus.resume)
                    stateD = RUN;
            end
            ERROR: begin
                {pcEn, ifIdEn, idExEn, exMemEn, memWbEn} = '0;
            end
            default: begin
                {pcEn, ifIdEn, idExEn, exMemEn, memWbEn} = '0;
                stateD = RUN;
            end
        endcase
        if (!rst) begin
            {pcEn, ifIdEn, idExEn, exMemEn, memWbEn} = '0;
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
        end
    end

    assign bus.pc_en       = pcEn;
    assign bus.if_id_en    = ifIdEn;
    assign bus.if_id_flush = ifIdFlush;
    assign bus.id_ex_en    = idExEn;
    assign bus.id_ex_flush = idExFlush;
    assign bus.ex_mem_en   = exMemEn;
    assign bus.mem_wb_en   = memWbEn;
    assign bus.halted      = (stateQ == HALTED);
    assign bus.err         = (stateQ == ERROR);

    fwd_unit u_fwd_a (
        .rs      (bus.id_rs1),
        .exmemRd (bus.exmem_rd),
        .exmemWr (bus.exmem_reg_write),
        .memwbRd (bus.memwb_rd),
        .memwbWr (bus.memwb_reg_write),
        .sel     (bus.fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs      (bus.id_rs2),
        .exmemRd (bus.exmem_rd),
        .exmemWr (bus.exmem_reg_write),
        .memwbRd (bus.memwb_rd),
        .memwbWr (bus.memwb_reg_write),
        .sel     (bus.fwd_b)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stallCnt, flushCnt;
    logic        stallEvt, flushEvt;

    // only a load-use bubble flushes ID/EX without also flushing IF/ID
    assign stallEvt = (stateQ == MEM_WAIT) || (idExFlush && !ifIdFlush);
    assign flushEvt = idExFlush && ifIdFlush && (stateQ != DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallEvt && (stallCnt != '1))
                stallCnt <= stallCnt + 16'd1;
            if (flushEvt && (flushCnt != '1))
                flushCnt <= flushCnt + 16'd1;
        end
    end

    assign bus.stall_cnt = stallCnt;
    assign bus.flush_cnt = flushCnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: hazards, forwarding, timeout, halt/drain, reset.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
    localparam logic [6:0] CTL_RUN   = 7'b1101011;
    localparam logic [6:0] CTL_LU    = 7'b0001111;
    localparam logic [6:0] CTL_BR    = 7'b1111111;
    localparam logic [6:0] CTL_OFF   = 7'b0000000;
    localparam logic [6:0] CTL_DRAIN = 7'b0111011;
    localparam logic [6:0] CTL_RST   = 7'b0010100;

    logic clk = 1'b0;
    logic rst;
    int   vecCnt = 0;
    int   errCnt = 0;
    logic [6:0] ctl;

    pipe_ctrl_if pif ();

    pipe_ctrl #(.WAIT_MAX(15), .DRAIN_CYC(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pif.slave)
    );

    always #5 clk = ~clk;

    assign ctl = {pif.pc_en, pif.if_id_en, pif.if_id_flush, pif.id_ex_en,
                  pif.id_ex_flush, pif.ex_mem_en, pif.mem_wb_en};

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIns();
        pif.id_rs1 = '0;          pif.id_rs2 = '0;          pif.id_uses_rs2 = 1'b0;
        pif.idex_rd = '0;         pif.idex_mem_read = 1'b0;
        pif.exmem_rd = '0;        pif.exmem_reg_write = 1'b0;
        pif.memwb_rd = '0;        pif.memwb_reg_write = 1'b0;
        pif.branch_taken = 1'b0;  pif.mem_busy = 1'b0;
        pif.halt_req = 1'b0;      pif.resume = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clearIns();
        #2;
        checkVal("rst_ctl", ctl, CTL_RST);
        checkVal("rst_halted", pif.halted, 0);
        checkVal("rst_err", pif.err, 0);
        step(); step();
        rst = 1'b1; #1;
        checkVal("idle", ctl, CTL_RUN);

        // load-use on rs1: one bubble, then normal issue
        pif.idex_mem_read = 1'b1; pif.idex_rd = 3'd3; pif.id_rs1 = 3'd3; #1;
        checkVal("lu_rs1", ctl, CTL_LU);
        step();
        pif.idex_mem_read = 1'b0; #1;
        checkVal("lu_after", ctl, CTL_RUN);

        pif.idex_mem_read = 1'b1; pif.id_rs1 = 3'd1; pif.id_rs2 = 3'd3; #1;
        checkVal("lu_rs2_unused", ctl, CTL_RUN);
        pif.id_uses_rs2 = 1'b1; #1;
        checkVal("lu_rs2", ctl, CTL_LU);
        pif.idex_rd = 3'd0; pif.id_rs2 = 3'd0; #1;
        checkVal("lu_rd0", ctl, CTL_RUN);
        pif.idex_rd = 3'd3; pif.id_rs2 = 3'd3; pif.branch_taken = 1'b1; #1;
        checkVal("br_over_lu", ctl, CTL_BR);
        step();
        clearIns(); #1;
        checkVal("br_after", ctl, CTL_RUN);

        // forwarding
        pif.exmem_rd = 3'd5; pif.memwb_rd = 3'd5; pif.id_rs1 = 3'd5;
        pif.exmem_reg_write = 1'b1; pif.memwb_reg_write = 1'b1; #1;
        checkVal("fwd_a_both", pif.fwd_a, 2'b10);
        checkVal("fwd_ctl", ctl, CTL_RUN);
        pif.exmem_reg_write = 1'b0; #1;
        checkVal("fwd_a_memwb", pif.fwd_a, 2'b01);
        pif.exmem_reg_write = 1'b1; pif.exmem_rd = 3'd4; pif.id_rs1 = 3'd4; pif.id_rs2 = 3'd5; #1;
        checkVal("fwd_a_exmem", pif.fwd_a, 2'b10);
        checkVal("fwd_b_memwb", pif.fwd_b, 2'b01);
        pif.exmem_rd = 3'd0; pif.memwb_rd = 3'd0; pif.id_rs1 = 3'd0; pif.id_rs2 = 3'd0; #1;
        checkVal("fwd_a_rd0", pif.fwd_a, 2'b00);
        checkVal("fwd_b_rd0", pif.fwd_b, 2'b00);
        clearIns(); #1;

        // 14 busy cycles: recover to RUN
        pif.mem_busy = 1'b1; #1;
        checkVal("busy_ctl", ctl, CTL_OFF);
        repeat (14) step();
        pif.mem_busy = 1'b0; #1;
        checkVal("busy14_ctl", ctl, CTL_RUN);
        step();
        checkVal("busy14_err", pif.err, 0);
        checkVal("busy14_run", ctl, CTL_RUN);

        // 15 busy cycles: ERROR on cycle 16, sticky, resume ignored
        pif.mem_busy = 1'b1;
        repeat (14) step();
        checkVal("busy15_pre", pif.err, 0);
        step();
        checkVal("timeout_err", pif.err, 1);
        checkVal("timeout_ctl", ctl, CTL_OFF);
        pif.mem_busy = 1'b0; pif.resume = 1'b1;
        step(); step();
        pif.resume = 1'b0; #1;
        checkVal("err_sticky", pif.err, 1);
        checkVal("err_ctl", ctl, CTL_OFF);
        rst = 1'b0; #1;
        checkVal("err_rst_ctl", ctl, CTL_RST);
        checkVal("err_rst_err", pif.err, 0);
        step();
        rst = 1'b1; #1;
        checkVal("err_rst_run", ctl, CTL_RUN);

        // halt: 3 drain cycles, halted, resume
        pif.halt_req = 1'b1; #1;
        checkVal("halt_req_ctl", ctl, CTL_RUN);
        step();
        pif.halt_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkVal($sformatf("drain%0d", i), ctl, CTL_DRAIN);
            step();
        end
        checkVal("halted", pif.halted, 1);
        checkVal("halted_ctl", ctl, CTL_OFF);
        pif.resume = 1'b1; step();
        pif.resume = 1'b0; #1;
        checkVal("resume_halted", pif.halted, 0);
        checkVal("resume_ctl", ctl, CTL_RUN);

        // busy during drain freezes the drain counter
        pif.halt_req = 1'b1; step();
        pif.halt_req = 1'b0; #1;
        checkVal("dbusy_d0", ctl, CTL_DRAIN);
        step();
        pif.mem_busy = 1'b1; #1;
        checkVal("dbusy_frozen", ctl, CTL_OFF);
        step(); step();
        pif.mem_busy = 1'b0; #1;
        checkVal("dbusy_d1", ctl, CTL_DRAIN);
        checkVal("dbusy_d1_h", pif.halted, 0);
        step();
        checkVal("dbusy_d2", ctl, CTL_DRAIN);
        step();
        checkVal("dbusy_halted", pif.halted, 1);
        pif.resume = 1'b1; step();
        pif.resume = 1'b0; #1;
        checkVal("dbusy_resume", ctl, CTL_RUN);

        // reset mid-DRAIN
        pif.halt_req = 1'b1; step();
        pif.halt_req = 1'b0; step();
        rst = 1'b0; #1;
        checkVal("rdrain_halted", pif.halted, 0);
        checkVal("rdrain_ctl", ctl, CTL_RST);
        step();
        rst = 1'b1; #1;
        checkVal("rdrain_run", ctl, CTL_RUN);
        repeat (4) step();
        checkVal("rdrain_no_resid", pif.halted, 0);
        checkVal("rdrain_ctl2", ctl, CTL_RUN);

        // reset mid-MEM_WAIT leaves no residual count
        pif.mem_busy = 1'b1;
        repeat (10) step();
        rst = 1'b0; #1;
        checkVal("rwait_ctl", ctl, CTL_RST);
        pif.mem_busy = 1'b0; step();
        rst = 1'b1; #1;
        checkVal("rwait_run", ctl, CTL_RUN);
        pif.mem_busy = 1'b1;
        repeat (14) step();
        checkVal("rwait_no_resid", pif.err, 0);
        pif.mem_busy = 1'b0; #1;
        checkVal("rwait_recover", ctl, CTL_RUN);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum consecutive mem_busy cycles before the error state.
REQ-002 SHALL have parameter DRAIN_CYC, default 3: cycles spent draining the pipeline on halt.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have ports id_rs1/id_rs2, input, 3 each, plus id_uses_rs2, input, 1: ID-stage source registers.
REQ-006 SHALL have ports idex_rd, input, 3, and idex_mem_read, input, 1: load in EX.
REQ-007 SHALL have ports exmem_rd, input, 3, and exmem_reg_write, input, 1; memwb_rd, input, 3, and memwb_reg_write, input, 1.
REQ-008 SHALL have ports branch_taken, mem_busy, halt_req and resume, input, 1 each.
REQ-009 SHALL have outputs pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en and mem_wb_en, 1 each: pipeline register controls.
REQ-010 SHALL have outputs fwd_a/fwd_b, 2 each (00 regfile, 10 EX/MEM, 01 MEM/WB); halted, 1; err, 1.

Function
REQ-011 SHALL implement FSM states RUN, MEM_WAIT, DRAIN, HALTED, ERROR.
REQ-012 In RUN with no event, all *_en SHALL be 1 and all flushes 0.
REQ-013 Event priority in RUN, highest first: mem_busy, branch_taken, load-use, halt_req.
REQ-014 A load-use hazard is idex_mem_read & idex_rd!=0 & (idex_rd==id_rs1 | id_uses_rs2 & idex_rd==id_rs2).
REQ-015 On load-use, in the same cycle: pc_en=0, if_id_en=0, id_ex_flush=1. This inserts exactly one bubble, and the state remains RUN.
REQ-016 On branch_taken, in the same cycle: if_id_flush=1 and id_ex_flush=1, with pc_en=1 so the target loads. branch_taken overrides load-use.
REQ-017 mem_busy in RUN or MEM_WAIT SHALL give pc_en, if_id_en, id_ex_en and ex_mem_en = 0, and mem_wb_en=0. It is the same cycle (Mealy), with next state MEM_WAIT.
REQ-018 MEM_WAIT SHALL count the busy cycles in a ceil(log2(WAIT_MAX+1))-bit counter. It returns to RUN on the first cycle mem_busy=0, and the counter clears.
REQ-019 When the count reaches WAIT_MAX with mem_busy still 1, the next state SHALL be ERROR. In ERROR: err=1, all enables 0, exit only by reset.
REQ-020 halt_req in RUN with no higher event SHALL enter DRAIN. DRAIN holds pc_en=0 and if_id_flush=1 for DRAIN_CYC cycles, with the other stages enabled, then enters HALTED.
REQ-021 mem_busy during DRAIN SHALL freeze the drain counter and all enables until it deasserts; the same timeout rule applies.
REQ-022 In HALTED: halted=1, all enables 0. A resume pulse returns to RUN on the next edge. resume in any other state is ignored.
REQ-023 fwd_a SHALL be 10 if exmem_reg_write & exmem_rd!=0 & exmem_rd==id_rs1. Otherwise it is 01 on the MEM/WB match with memwb_rd!=0, otherwise 00. fwd_b is the same for id_rs2. EX/MEM wins on a double match.
REQ-024 Forwarding SHALL be purely combinational and independent of the FSM state.

Reset
REQ-025 rst=0 SHALL asynchronously force state RUN, counters 0, err=0 and halted=0.
REQ-026 While in reset, all *_en SHALL be 0 and all flushes 1.
REQ-027 Reset asserted in mid-MEM_WAIT or mid-DRAIN SHALL abandon the operation, with no residual count.

Configuration
REQ-028 Macro PIPE_CTRL_PERF_EN, when defined, SHALL add outputs stall_cnt and flush_cnt, 16 bits each, saturating.
REQ-029 stall_cnt increments on each load-use or MEM_WAIT cycle; flush_cnt increments on each branch_taken flush. Both clear on reset.
REQ-030 Without the macro, these ports and counters SHALL be absent, and the rest of the behaviour is identical.

Structure
REQ-031 The state enum and the fwd_sel encoding (FWD_RF, FWD_EXMEM, FWD_MEMWB) SHALL live in shared package pipe_pkg.
REQ-032 Forwarding SHALL be a sub-module fwd_unit, instantiated once for each of operands A and B.

Verification
REQ-033 Load-use test: idex_mem_read=1, idex_rd=3, id_rs1=3 SHALL give pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle, then RUN enables.
REQ-034 Branch-versus-hazard test: branch_taken=1 together with a load-use SHALL give if_id_flush=1, id_ex_flush=1, pc_en=1.
REQ-035 Timeout test: mem_busy held 15 cycles SHALL give err=1 on cycle 16 and stay there. A busy run of 14 cycles SHALL return to RUN.
REQ-036 Halt test: halt_req pulse SHALL give 3 cycles of pc_en=0/if_id_flush=1, then halted=1. A resume pulse SHALL then return to RUN the next cycle.
REQ-037 Forwarding test: exmem_rd=memwb_rd=id_rs1=5, both writes 1, SHALL give fwd_a=10. With rd=0, it SHALL give fwd_a=00.
REQ-038 Reset test: rst=0 asserted mid-DRAIN SHALL immediately show halted=0 and all flushes 1. After release, the state SHALL be RUN.
